data_cache: RTL and testbench

- Direct-mapped, write-through, no-write-allocate data cache between the memory stage and main data memory.
- Read hits return a word in the same cycle.
- Misses refill a multi-word line over a request/acknowledge memory port, with the pipeline frozen through `stall`.
- `stall` feeds the hazard unit. The memory stage keeps funct3 sign/zero extension; the cache only handles words and byte enables.

---
 rtl/data_cache_pkg.sv | 42 ++++
 rtl/data_cache_data_array.sv | 45 ++++
 rtl/data_cache.sv | 196 +++++++++++++++++++
 tb/tb_data_cache.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_cache_pkg.sv
// Shared types and address-field helpers for the data cache.
package data_cache_pkg;

    // Cache controller states.
    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        WDONE
    } cacheState_t;

    // Default geometry and the fixed byte-offset field.
    localparam int DEF_SETS       = 64;
    localparam int DEF_LINE_WORDS = 4;
    localparam int BYTE_BITS      = 2;
    localparam int DEF_WORD_BITS  = $clog2(DEF_LINE_WORDS);
    localparam int DEF_INDEX_BITS = $clog2(DEF_SETS);

    // One beat on the memory port, held in registers while it is outstanding.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } memBeat_t;

    // Width of the word-within-line field.
    function automatic int wordBits(input int lineWords);
        return $clog2(lineWords);
    endfunction

    // Width of the set-index field.
    function automatic int indexBits(input int sets);
        return $clog2(sets);
    endfunction

    // Width of the tag field: everything above index, word and byte.
    function automatic int tagBits(input int addrWidth, input int sets, input int lineWords);
        return addrWidth - BYTE_BITS - $clog2(lineWords) - $clog2(sets);
    endfunction

endpackage

// File: rtl/data_cache_data_array.sv
// SETS x LINE_WORDS word storage, byte-writable, combinational read.
module cache_data_array
    import data_cache_pkg::*;
#(
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                           clk,
    input  logic                           we,
    input  logic [indexBits(SETS)-1:0]     wrSet,
    input  logic [wordBits(LINE_WORDS)-1:0] wrWord,
    input  logic [3:0]                     wrBe,
    input  logic [31:0]                    wrData,
    input  logic [indexBits(SETS)-1:0]     rdSet,
    input  logic [wordBits(LINE_WORDS)-1:0] rdWord,
    output logic [31:0]                    rdData
);

    localparam int DEPTH = SETS * LINE_WORDS;
    localparam int AW    = indexBits(SETS) + wordBits(LINE_WORDS);

    logic [AW-1:0] wrAddr;
    logic [AW-1:0] rdAddr;

    assign wrAddr = {wrSet, wrWord};
    assign rdAddr = {rdSet, rdWord};

    // Each byte lane is its own array so a byte enable only touches its lane.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : gLane
            logic [7:0] laneMem [DEPTH];

            // Lane write on the rising edge when its enable is set.
            always_ff @(posedge clk) begin
                if (we && wrBe[gi]) begin
                    laneMem[wrAddr] <= wrData[gi*8 +: 8];
                end
            end

            assign rdData[gi*8 +: 8] = laneMem[rdAddr];
        end
    endgenerate

endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
module data_cache
    import data_cache_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int SETS       = DEF_SETS,
    parameter int LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpu_read,
    input  logic                  cpu_write,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic [3:0]            cpu_be,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  stall,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_be,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_ack,
    output logic [31:0]           hit_count,
    output logic [31:0]           miss_count
);

    localparam int WORD_BITS  = wordBits(LINE_WORDS);
    localparam int INDEX_BITS = indexBits(SETS);
    localparam int TAG_BITS   = tagBits(ADDR_WIDTH, SETS, LINE_WORDS);
    localparam logic [WORD_BITS-1:0] LAST_BEAT = WORD_BITS'(LINE_WORDS - 1);

    // Address fields of the current CPU request.
    logic [WORD_BITS-1:0]  cpuWord;
    logic [INDEX_BITS-1:0] cpuIndex;
    logic [TAG_BITS-1:0]   cpuTag;
    logic [1:0]            unusedByteBits;

    assign cpuWord        = cpu_addr[BYTE_BITS +: WORD_BITS];
    assign cpuIndex       = cpu_addr[BYTE_BITS + WORD_BITS +: INDEX_BITS];
    assign cpuTag         = cpu_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign unusedByteBits = cpu_addr[1:0];

    // Controller state, line metadata and statistics.
    cacheState_t          stateReg;
    logic [SETS-1:0]      validReg;
    logic [TAG_BITS-1:0]  tagReg [SETS];
    logic [WORD_BITS-1:0] beatReg;
    logic [31:0]          hitCountReg;
    logic [31:0]          missCountReg;
    memBeat_t             memBeatReg;
    logic                 memReqReg;

    logic hit;
    logic ackSeen;
    logic lastBeat;
    logic [ADDR_WIDTH-1:0] refillBase;

    assign hit        = validReg[cpuIndex] && (tagReg[cpuIndex] == cpuTag);
    assign ackSeen    = mem_ack && memReqReg;
    assign lastBeat   = (beatReg == LAST_BEAT);
    assign refillBase = {cpuTag, cpuIndex, {WORD_BITS{1'b0}}, 2'b00};

    // Data array write port: store hits in IDLE, refill beats in REFILL.
    logic                  arrWe;
    logic [WORD_BITS-1:0]  arrWord;
    logic [3:0]            arrBe;
    logic [31:0]           arrData;
    logic [31:0]           arrRdata;

    // Select who writes the data array this cycle.
    always_comb begin
        arrWe   = 1'b0;
        arrWord = cpuWord;
        arrBe   = cpu_be;
        arrData = cpu_wdata;
        if (!rst) begin
            if (stateReg == IDLE && cpu_write && hit) begin
                arrWe = 1'b1;
            end else if (stateReg == REFILL && ackSeen) begin
                arrWe   = 1'b1;
                arrWord = beatReg;
                arrBe   = 4'hF;
                arrData = mem_rdata;
            end
        end
    end

    cache_data_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) uDataArray (
        .clk    (clk),
        .we     (arrWe),
        .wrSet  (cpuIndex),
        .wrWord (arrWord),
        .wrBe   (arrBe),
        .wrData (arrData),
        .rdSet  (cpuIndex),
        .rdWord (cpuWord),
        .rdData (arrRdata)
    );

    // Freeze the pipeline on any miss, any store, and while memory is busy.
    always_comb begin
        stall = 1'b0;
        case (stateReg)
            IDLE:    stall = cpu_write || (cpu_read && !hit);
            REFILL:  stall = 1'b1;
            WRITE:   stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    // Controller FSM with registered memory-port outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            stateReg     <= IDLE;
            validReg     <= '0;
            beatReg      <= '0;
            hitCountReg  <= '0;
            missCountReg <= '0;
            memBeatReg   <= '0;
            memReqReg    <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (cpu_write) begin
                        // A read issued together with a store is ignored.
                        memReqReg        <= 1'b1;
                        memBeatReg.addr  <= 32'({cpu_addr[ADDR_WIDTH-1:2], 2'b00});
                        memBeatReg.wdata <= cpu_wdata;
                        memBeatReg.be    <= cpu_be;
                        memBeatReg.we    <= 1'b1;
                        stateReg         <= WRITE;
                    end else if (cpu_read) begin
                        if (hit) begin
                            if (hitCountReg != '1) begin
                                hitCountReg <= hitCountReg + 32'd1;
                            end
                        end else begin
                            if (missCountReg != '1) begin
                                missCountReg <= missCountReg + 32'd1;
                            end
                            // The line is being overwritten; it is invalid until the last beat lands.
                            validReg[cpuIndex] <= 1'b0;
                            beatReg            <= '0;
                            memReqReg          <= 1'b1;
                            memBeatReg.addr    <= 32'(refillBase);
                            memBeatReg.wdata   <= '0;
                            memBeatReg.be      <= '0;
                            memBeatReg.we      <= 1'b0;
                            stateReg           <= REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (ackSeen) begin
                        beatReg <= beatReg + WORD_BITS'(1);
                        memBeatReg.addr[BYTE_BITS +: WORD_BITS] <= beatReg + WORD_BITS'(1);
                        if (lastBeat) begin
                            validReg[cpuIndex] <= 1'b1;
                            tagReg[cpuIndex]   <= cpuTag;
                            memReqReg          <= 1'b0;
                            stateReg           <= IDLE;
                        end
                    end
                end
                WRITE: begin
                    if (ackSeen) begin
                        memReqReg     <= 1'b0;
                        memBeatReg.we <= 1'b0;
                        stateReg      <= WDONE;
                    end
                end
                WDONE: begin
                    // The store retires here; the held cpu_write is consumed.
                    stateReg <= IDLE;
                end
                default: stateReg <= IDLE;
            endcase
        end
    end

    assign cpu_rdata  = arrRdata;
    assign mem_req    = memReqReg;
    assign mem_we     = memBeatReg.we;
    assign mem_addr   = memBeatReg.addr[ADDR_WIDTH-1:0];
    assign mem_wdata  = memBeatReg.wdata;
    assign mem_be     = memBeatReg.be;
    assign hit_count  = hitCountReg;
    assign miss_count = missCountReg;

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache against a line-level cache model.
module tb_data_cache;

    localparam int SETS       = 64;
    localparam int LINE_WORDS = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_addr, cpu_wdata;
    logic [3:0]  cpu_be;
    logic [31:0] cpu_rdata;
    logic        stall, mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [31:0] hit_count, miss_count;

    always #5 clk = ~clk;

    data_cache #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_read   (cpu_read),
        .cpu_write  (cpu_write),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_be     (cpu_be),
        .cpu_rdata  (cpu_rdata),
        .stall      (stall),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_be     (mem_be),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    int nCompared   = 0;
    int nMismatched = 0;
    int txnCount    = 0;

    // Backing memory (word address -> word) and the cache model: which tag each set holds.
    logic [31:0] bmem [logic [31:0]];
    bit          mValid [SETS];
    logic [21:0] mTag [SETS];
    int unsigned mHit = 0;
    int unsigned mMiss = 0;

    bit          immediateAck = 1'b1;
    int          readBeats = 0;
    int          writeBeats = 0;
    logic [31:0] lastRdata;
    int          lastStallCycles;

    function automatic logic [31:0] memRead(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        if (bmem.exists(w)) return bmem[w];
        return {w[15:0] ^ 16'h5A5A, w[17:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("FAIL %s: actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder: acks on the falling edge so the beat completes at the next rise.
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (mem_req === 1'b1) begin
                if (immediateAck || ($urandom_range(0, 1) == 1)) begin
                    mem_ack = 1'b1;
                    if (!mem_we) mem_rdata = memRead(mem_addr);
                end
            end else if ($urandom_range(0, 7) == 0) begin
                mem_ack = 1'b1;   // stray ack with no request must be ignored
            end
        end
    end

    // Compare process: checks beats, read data and idle behaviour every cycle.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst === 1'b0) begin
                if (mem_req && mem_ack) begin
                    if (!mem_we) begin
                        chk("refill_addr", mem_addr, (cpu_addr & ~32'hF) + 32'(readBeats * 4));
                        readBeats++;
                    end else begin
                        chk("write_addr", mem_addr, cpu_addr & ~32'h3);
                        chk("write_data", mem_wdata, cpu_wdata);
                        chk("write_be", {28'b0, mem_be}, {28'b0, cpu_be});
                        writeBeats++;
                    end
                end
                if (mem_req) chk("beat_kind", {31'b0, mem_we}, {31'b0, cpu_write});
                if (cpu_read && !cpu_write && !stall) chk("read_data", cpu_rdata, memRead(cpu_addr));
                if (!cpu_read && !cpu_write) begin
                    chk("idle_stall", {31'b0, stall}, 32'd0);
                    chk("idle_req", {31'b0, mem_req}, 32'd0);
                end
            end
        end
    end

    // Retire the transaction, leave one idle cycle, then check the counters.
    task automatic finishTxn();
        @(posedge clk);
        #1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        @(negedge clk);
        #2;
        chk("hit_count", hit_count, mHit);
        chk("miss_count", miss_count, mMiss);
    endtask

    task automatic doRead(input logic [31:0] a, output bit wasHit);
        int   set;
        bit   hit;
        bit   done;
        set  = int'(a[9:4]);
        hit  = mValid[set] && (mTag[set] == a[31:10]);
        done = 1'b0;
        @(posedge clk);
        #1;
        readBeats  = 0;
        writeBeats = 0;
        cpu_addr   = a;
        cpu_read   = 1'b1;
        cpu_write  = 1'b0;
        cpu_wdata  = $urandom;
        cpu_be     = 4'($urandom);
        lastStallCycles = 0;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            #2;
            if (cyc == 0) chk("first_stall_rd", {31'b0, stall}, {31'b0, !hit});
            if (!stall) begin
                done = 1'b1;
                break;
            end
            lastStallCycles++;
        end
        if (!done) chk("read_timeout", 32'd1, 32'd0);
        lastRdata = cpu_rdata;
        chk("refill_beats", readBeats, hit ? 0 : LINE_WORDS);
        chk("rd_write_beats", writeBeats, 0);
        if (!hit) begin
            mValid[set] = 1'b1;
            mTag[set]   = a[31:10];
            mMiss++;
        end
        mHit++;
        txnCount++;
        $display("txn %0d: read  addr=%h %s rdata=%h stall=%0d", txnCount, a, hit ? "hit " : "miss", lastRdata, lastStallCycles);
        finishTxn();
        wasHit = hit;
    endtask

    task automatic doWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be, input bit alsoRead);
        int          set;
        bit          hit;
        bit          done;
        logic [31:0] mask;
        logic [31:0] w;
        set  = int'(a[9:4]);
        hit  = mValid[set] && (mTag[set] == a[31:10]);
        done = 1'b0;
        @(posedge clk);
        #1;
        readBeats  = 0;
        writeBeats = 0;
        cpu_addr   = a;
        cpu_read   = alsoRead;
        cpu_write  = 1'b1;
        cpu_wdata  = d;
        cpu_be     = be;
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge clk);
            #2;
            if (cyc == 0) chk("first_stall_wr", {31'b0, stall}, 32'd1);
            if (!stall) begin
                chk("wdone_req", {31'b0, mem_req}, 32'd0);
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("write_timeout", 32'd1, 32'd0);
        chk("write_beats", writeBeats, 1);
        chk("wr_refill_beats", readBeats, 0);
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        w    = {a[31:2], 2'b00};
        bmem[w] = (memRead(w) & ~mask) | (d & mask);
        txnCount++;
        $display("txn %0d: write addr=%h %s data=%h be=%b rd=%0d", txnCount, a, hit ? "hit " : "miss", d, be, alsoRead);
        finishTxn();
    endtask

    initial begin
        bit h;
        bit done;
        int acks;
        rst       = 1'b1;
        cpu_read  = 1'b0;
        cpu_write = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        cpu_be    = '0;
        for (int s = 0; s < SETS; s++) mValid[s] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        chk("reset_stall", {31'b0, stall}, 32'd0);
        chk("reset_req", {31'b0, mem_req}, 32'd0);
        chk("reset_we", {31'b0, mem_we}, 32'd0);
        chk("reset_hits", hit_count, 32'd0);
        chk("reset_misses", miss_count, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Cold miss with immediate acks.
        for (int i = 0; i < 4; i++) bmem[32'h100 + 32'(i * 4)] = 32'hA0 + 32'(i);
        doRead(32'h0000_0104, h);
        chk("cold_rdata", lastRdata, 32'h0000_00A1);
        chk("cold_stall_cycles", lastStallCycles, 5);
        chk("cold_miss_count", miss_count, 32'd1);
        chk("cold_hit_count", hit_count, 32'd1);

        // Hit after refill.
        doRead(32'h0000_010C, h);
        chk("hit_rdata", lastRdata, 32'h0000_00A3);
        chk("hit_flag", {31'b0, h}, 32'd1);

        // Write hit with one byte enabled.
        doWrite(32'h0000_0104, 32'h0000_BB00, 4'b0010, 1'b0);
        doRead(32'h0000_0104, h);
        chk("byte_write_rdata", lastRdata, 32'h0000_BBA1);
        chk("byte_write_hit", {31'b0, h}, 32'd1);

        // Write miss does not allocate.
        doWrite(32'h0000_2000, 32'h1234_5678, 4'hF, 1'b0);
        doRead(32'h0000_2000, h);
        chk("write_miss_no_alloc", {31'b0, h}, 32'd0);
        chk("write_miss_rdata", lastRdata, 32'h1234_5678);

        // Conflict eviction in set 16.
        doRead(32'h0000_0100, h);
        chk("evict_first_hit", {31'b0, h}, 32'd1);
        doRead(32'h0000_0500, h);
        chk("evict_conflict_miss", {31'b0, h}, 32'd0);
        doRead(32'h0000_0100, h);
        chk("evict_remiss", {31'b0, h}, 32'd0);

        // Reset in the middle of a refill.
        @(posedge clk);
        #1;
        readBeats = 0;
        cpu_addr  = 32'h0000_0500;
        cpu_read  = 1'b1;
        acks = 0;
        done = 1'b0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            #2;
            if (mem_req && mem_ack) acks++;
            if (acks == 2) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("abort_wait_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        cpu_read = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("abort_req", {31'b0, mem_req}, 32'd0);
        chk("abort_stall", {31'b0, stall}, 32'd0);
        chk("abort_hits", hit_count, 32'd0);
        chk("abort_misses", miss_count, 32'd0);
        for (int s = 0; s < SETS; s++) mValid[s] = 1'b0;
        mHit  = 0;
        mMiss = 0;
        doRead(32'h0000_0100, h);
        chk("after_abort_miss", {31'b0, h}, 32'd0);
        doRead(32'h0000_0500, h);
        chk("partial_line_miss", {31'b0, h}, 32'd0);

        // Randomized traffic over a small address pool to force hits and conflicts.
        immediateAck = 1'b0;
        for (int n = 0; n < 250; n++) begin
            int          op;
            logic [31:0] a;
            op = $urandom_range(0, 99);
            a  = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(14, 17)) << 4) |
                 (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if (op < 55) begin
                doRead(a, h);
            end else if (op < 85) begin
                doWrite(a, $urandom, 4'($urandom), 1'b0);
            end else if (op < 92) begin
                doWrite(a, $urandom, 4'($urandom), 1'b1);
            end else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
